sdram_arbit: RTL

//  Owns the SDRAM command/address/data pins. It grants the bus to one of four

---
 rtl/sdram_arbit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sdram_arbit.sv
// sdram_arbit: owns the SDRAM command/address/data pins and hands the bus to
// one of four masters (init, auto-refresh, write, read).
//
// Ports
//   sys_clk_i, rst_n_i          clock, asynchronous active-low reset
//   init_*                      init sequencer command/bank/address, init_end level
//   auto_refresh_*              refresh request/end/command/bank/address, grant out
//   wr_* / rd_*                 write/read request/end/command/bank/address, grants out
//   wr_data, wr_sdram_en        write data and its tristate enable
//   sdram_*                     SDRAM pins (cke, cs_n, ras_n, cas_n, we_n, ba, addr, dq)
//
// Configuration
//   SDRAM_ARBIT_RR_EN  when defined, write and read alternate when both are
//                      pending; otherwise write always beats read. Refresh
//                      always has the highest priority.
module sdram_arbit #(
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQ_W   = 16
) (
    input  logic              sys_clk_i,
    input  logic              rst_n_i,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              auto_refresh_req,
    input  logic              auto_refresh_end,
    input  logic [3:0]        auto_refresh_cmd,
    input  logic [BA_W-1:0]   auto_refresh_ba,
    input  logic [ADDR_W-1:0] auto_refresh_addr,
    output logic              auto_refresh_en,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DQ_W-1:0]   wr_data,
    input  logic              wr_sdram_en,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DQ_W-1:0]   sdram_dq
);

    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {IDLE, ARBIT, AREF, WRITE, READ} state_t;

    state_t state, state_nxt;
    logic   wr_wins;
    logic [3:0] cmd;

`ifdef SDRAM_ARBIT_RR_EN
    // Remembers which of write/read was served last so a contended
    // arbitration goes to the other one.
    logic last_wr;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            last_wr <= 1'b0;
        else if (state == ARBIT && state_nxt == WRITE)
            last_wr <= 1'b1;
        else if (state == ARBIT && state_nxt == READ)
            last_wr <= 1'b0;
    end

    assign wr_wins = !(rd_req && last_wr);
`else
    assign wr_wins = 1'b1;
`endif

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (init_end) state_nxt = ARBIT;
            ARBIT: begin
                if (auto_refresh_req)       state_nxt = AREF;
                else if (wr_req && wr_wins) state_nxt = WRITE;
                else if (rd_req)            state_nxt = READ;
            end
            AREF:  if (auto_refresh_end) state_nxt = ARBIT;
            WRITE: if (wr_end)           state_nxt = ARBIT;
            READ:  if (rd_end)           state_nxt = ARBIT;
            default: state_nxt = IDLE;
        endcase
    end

    assign auto_refresh_en = (state == AREF);
    assign wr_en           = (state == WRITE);
    assign rd_en           = (state == READ);

    // Pins follow the current owner; reset forces IDLE so the init
    // sequencer's fields appear on the pins immediately.
    always_comb begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
        case (state)
            ARBIT: begin
                cmd        = CMD_NOP;
                sdram_ba   = '1;
                sdram_addr = '1;
            end
            AREF: begin
                cmd        = auto_refresh_cmd;
                sdram_ba   = auto_refresh_ba;
                sdram_addr = auto_refresh_addr;
            end
            WRITE: begin
                cmd        = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            READ: begin
                cmd        = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke = 1'b1;
    assign sdram_dq  = (state == WRITE && wr_sdram_en) ? wr_data : {DQ_W{1'bz}};

endmodule
